// File: rtl/noise_pkg.sv
// noise_pkg: shared types and constants for the APU noise channel front end.
package noise_pkg;

  typedef enum logic [1:0] {
    NR41 = 2'd0,
    NR42 = 2'd1,
    NR43 = 2'd2,
    NR44 = 2'd3
  } noise_reg_e;

  // Shift codes at or above this value freeze the frequency timer.
  localparam int NOISE_SHIFT_MAX = 14;
  localparam int LEN_MAX         = 64;

  // Divisor table {8,16,32,48,64,80,96,112}: code 0 is the odd one out,
  // every other code is simply r*16.
  function automatic logic [6:0] noise_div(input logic [2:0] r);
    return (r == 3'd0) ? 7'd8 : {r, 4'b0000};
  endfunction

endpackage

// File: rtl/noise_envelope.sv
// noise_envelope: volume envelope for the noise channel.
// Only built when NOISE_ENVELOPE_EN is defined; otherwise the top keeps a fixed volume.
`ifdef NOISE_ENVELOPE_EN
module noise_envelope (
  input  logic       clk,
  input  logic       reset,
  input  logic       trigger,
  input  logic       env_step,
  input  logic [3:0] init_vol,
  input  logic       env_up,
  input  logic [2:0] env_period,
  output logic [3:0] volume
);

  logic [3:0] volume_q;
  logic [2:0] env_timer_q;

  // Envelope timer down-count and saturating volume step; trigger reloads both
  always_ff @(posedge clk) begin
    if (reset) begin
      volume_q    <= 4'd0;
      env_timer_q <= 3'd0;
    end else if (trigger) begin
      volume_q    <= init_vol;
      env_timer_q <= env_period;
    end else if (env_step && (env_period != 3'd0)) begin
      // A timer at 1 reaches zero on this tick; a timer left at 0 by a
      // zero-period trigger is treated as already expired.
      if (env_timer_q <= 3'd1) begin
        env_timer_q <= env_period;
        if (env_up && (volume_q != 4'd15)) begin
          volume_q <= volume_q + 4'd1;
        end else if (!env_up && (volume_q != 4'd0)) begin
          volume_q <= volume_q - 4'd1;
        end
      end else begin
        env_timer_q <= env_timer_q - 3'd1;
      end
    end
  end

  assign volume = volume_q;

endmodule
`endif

// File: rtl/noise_ctrl.sv
// noise_ctrl: NR41-NR44 register decode plus length, envelope and frequency
// sequencing for the noise channel. Optional feature macro: NOISE_ENVELOPE_EN
// (volume envelope; when undefined, volume is fixed at the trigger value).
module noise_ctrl #(
  parameter int TIMER_W = 20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       slow_clk_en,
  input  logic       cpu_en,
  input  logic       reg_wr,
  input  logic [1:0] reg_addr,
  input  logic [7:0] reg_wdata,
  input  logic       len_tick,
  input  logic       env_tick,
  input  logic       play,
  output logic       new_width,
  output logic       width_write,
  output logic       init,
  output logic       next_step,
  output logic [3:0] sample,
  output logic       enabled,
  output logic       dac_on
);
  import noise_pkg::*;

  logic               wr;
  logic               wr_nr41;
  logic               wr_nr42;
  logic               wr_nr43;
  logic               wr_nr44;
  logic               trigger;

  logic [7:0]         nr42_q;
  logic [3:0]         shift_q;
  logic [2:0]         div_code_q;
  logic               length_en_q;
  logic [6:0]         len_cnt_q;
  logic [TIMER_W-1:0] timer_q;
  logic [TIMER_W-1:0] period;
  logic               enabled_q;
  logic               init_q;
  logic [3:0]         volume;

  logic               freq_running;
  logic               len_step;
  logic               len_expire;
  logic               env_step;

  assign wr      = cpu_en & reg_wr;
  assign wr_nr41 = wr & (reg_addr == NR41);
  assign wr_nr42 = wr & (reg_addr == NR42);
  assign wr_nr43 = wr & (reg_addr == NR43);
  assign wr_nr44 = wr & (reg_addr == NR44);
  assign trigger = wr_nr44 & reg_wdata[7];

  assign period       = TIMER_W'(noise_div(div_code_q)) << shift_q;
  assign freq_running = shift_q < 4'(NOISE_SHIFT_MAX);

  // A trigger or an NR41 write in the same cycle swallows the length tick.
  assign len_step   = slow_clk_en & len_tick & length_en_q & (len_cnt_q != 7'd0)
                      & ~trigger & ~wr_nr41;
  assign len_expire = len_step & (len_cnt_q == 7'd1);
  assign env_step   = slow_clk_en & env_tick;

  // Register file: NR42 in full, NR43 shift/divisor fields, NR44 length enable
  always_ff @(posedge clk) begin
    if (reset) begin
      nr42_q      <= 8'd0;
      shift_q     <= 4'd0;
      div_code_q  <= 3'd0;
      length_en_q <= 1'b0;
    end else begin
      if (wr_nr42) begin
        nr42_q <= reg_wdata;
      end
      if (wr_nr43) begin
        shift_q    <= reg_wdata[7:4];
        div_code_q <= reg_wdata[2:0];
      end
      if (wr_nr44) begin
        length_en_q <= reg_wdata[6];
      end
    end
  end

  // Length counter: load from NR41, refill an empty counter on trigger, count down on len_tick
  always_ff @(posedge clk) begin
    if (reset) begin
      len_cnt_q <= 7'd0;
    end else if (wr_nr41) begin
      len_cnt_q <= 7'(LEN_MAX) - {1'b0, reg_wdata[5:0]};
    end else if (trigger && (len_cnt_q == 7'd0)) begin
      len_cnt_q <= 7'(LEN_MAX);
    end else if (len_step) begin
      len_cnt_q <= len_cnt_q - 7'd1;
    end
  end

  // Frequency timer: down-counter with terminal count at 1; 0 just reloads silently
  always_ff @(posedge clk) begin
    if (reset) begin
      timer_q <= '0;
    end else if (trigger) begin
      timer_q <= period;
    end else if (slow_clk_en && enabled_q && freq_running) begin
      if (timer_q <= TIMER_W'(1)) begin
        timer_q <= period;
      end else begin
        timer_q <= timer_q - TIMER_W'(1);
      end
    end
  end

  // Channel enable and the one-cycle LFSR reload pulse
  always_ff @(posedge clk) begin
    if (reset) begin
      enabled_q <= 1'b0;
      init_q    <= 1'b0;
    end else begin
      init_q <= trigger;
      if (trigger) begin
        enabled_q <= dac_on;
      end else if ((wr_nr42 && (reg_wdata[7:3] == 5'd0)) || len_expire) begin
        enabled_q <= 1'b0;
      end
    end
  end

`ifdef NOISE_ENVELOPE_EN
  noise_envelope u_envelope (
    .clk        (clk),
    .reset      (reset),
    .trigger    (trigger),
    .env_step   (env_step),
    .init_vol   (nr42_q[7:4]),
    .env_up     (nr42_q[3]),
    .env_period (nr42_q[2:0]),
    .volume     (volume)
  );
`else
  logic [3:0] volume_q;
  logic       unused_env;

  // Fixed volume captured at trigger; envelope fields and env_tick are ignored
  always_ff @(posedge clk) begin
    if (reset) begin
      volume_q <= 4'd0;
    end else if (trigger) begin
      volume_q <= nr42_q[7:4];
    end
  end

  assign volume     = volume_q;
  assign unused_env = ^{env_step, nr42_q[3:0]};
`endif

  assign new_width   = reg_wdata[3];
  assign width_write = reg_wr & (reg_addr == NR43);
  assign init        = init_q;
  assign enabled     = enabled_q;
  assign dac_on      = nr42_q[7:3] != 5'd0;
  assign next_step   = enabled_q & (timer_q == TIMER_W'(1)) & freq_running;
  assign sample      = (enabled_q & play) ? volume : 4'd0;

endmodule
